// File: rtl/serial_pattern_detector_pkg.sv
// rtl/serial_pattern_detector_pkg.sv - shared defaults for the serial pattern detector
package serial_pattern_detector_pkg;

  localparam int          DEF_PAT_W   = 4;
  localparam logic [15:0] DEF_PATTERN = 16'b1011;
  localparam int          DEF_CNT_W   = 8;

  function automatic int fill_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != CNT_MAX)) begin
      q_d = q_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/serial_pattern_detector.sv
// rtl/serial_pattern_detector.sv - flags overlapping occurrences of PATTERN in a bit stream
module serial_pattern_detector
  import serial_pattern_detector_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN[PAT_W-1:0],
  parameter int               CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din,
  input  logic             clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             primed
);

  localparam int             FW   = fill_width(PAT_W);
  localparam logic [FW-1:0]  FULL = FW'(PAT_W);

  logic [PAT_W-1:0] hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             match_q, match_d;
  logic             primed_q, primed_d;

  always_comb begin
    hist_d   = hist_q;
    fill_d   = fill_q;
    match_d  = 1'b0;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      hist_d = {hist_q[PAT_W-2:0], din};
      if (fill_q != FULL) begin
        fill_d = fill_q + 1'b1;
      end
      // fill gate keeps an all-zero pattern from matching the reset history
      match_d = (fill_d == FULL) && (hist_d == PATTERN);
    end
    primed_d = (fill_d == FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q   <= '0;
      fill_q   <= '0;
      match_q  <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
      primed_q <= primed_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .inc  (match_d),
    .q    (match_cnt)
  );

  assign match  = match_q;
  assign primed = primed_q;

endmodule

// File: tb/tb_serial_pattern_detector.sv
// tb/tb_serial_pattern_detector.sv - directed self-checking bench for serial_pattern_detector
module tb_serial_pattern_detector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, din, clr;
  logic       ff_d, ff_q;
  logic       en_f;

  logic       match,   primed;
  logic [7:0] match_cnt;
  logic       match_s, primed_s;
  logic [1:0] match_cnt_s;
  logic       match_z, primed_z;
  logic [7:0] match_cnt_z;
  logic       match_f, primed_f;
  logic [7:0] match_cnt_f;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // stand-in for the upstream master_slave_d_flip_flop: one clk of delay
  always_ff @(posedge clk) ff_q <= ff_d;

  serial_pattern_detector dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .clr(clr),
    .match(match), .match_cnt(match_cnt), .primed(primed));

  serial_pattern_detector #(.CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .clr(clr),
    .match(match_s), .match_cnt(match_cnt_s), .primed(primed_s));

  serial_pattern_detector #(.PATTERN(4'b0000)) dut_z (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .clr(clr),
    .match(match_z), .match_cnt(match_cnt_z), .primed(primed_z));

  serial_pattern_detector dut_f (
    .clk(clk), .rst_n(rst_n), .en(en_f), .din(ff_q), .clr(clr),
    .match(match_f), .match_cnt(match_cnt_f), .primed(primed_f));

  task automatic step(input logic e, input logic d, input logic c);
    en  = e;
    din = d;
    clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [9:0] s;
    rst_n = 1'b0; en = 1'b0; din = 1'b0; clr = 1'b0; ff_d = 1'b0; en_f = 1'b1;
    #2;
    checks++;
    if ({match, match_cnt, primed} !== 10'd0) begin
      errors++; $display("FAIL reset_init got m=%0b cnt=%0d p=%0b want 0", match, match_cnt, primed);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    s = 10'b1011011011;
    for (int i = 9; i >= 0; i--) step(1'b1, s[i], 1'b0);
    checks++;
    if (match_cnt !== 8'd3) begin
      errors++; $display("FAIL reset_precount got %0d want 3", match_cnt);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({match, match_cnt, primed} !== 10'd0) begin
      errors++; $display("FAIL reset_async got m=%0b cnt=%0d p=%0b want 0", match, match_cnt, primed);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (primed !== 1'b0) begin
      errors++; $display("FAIL reset_primed3 got %0b want 0", primed);
    end
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (primed !== 1'b1 || match !== 1'b1) begin
      errors++; $display("FAIL reset_primed4 got p=%0b m=%0b want p=1 m=1", primed, match);
    end
  endtask

  task automatic test_overlap();
    logic [6:0] s;
    logic [6:0] exp_m;
    s     = 7'b1011011;
    exp_m = 7'b0001001;
    step(1'b0, 1'b0, 1'b1);
    for (int i = 6; i >= 0; i--) begin
      step(1'b1, s[i], 1'b0);
      checks++;
      if (match !== exp_m[i]) begin
        errors++; $display("FAIL overlap_bit%0d got %0b want %0b", 7 - i, match, exp_m[i]);
      end
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (match !== 1'b0 || match_cnt !== 8'd2) begin
      errors++; $display("FAIL overlap_end got m=%0b cnt=%0d want m=0 cnt=2", match, match_cnt);
    end
  endtask

  task automatic test_gaps();
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, i[0], 1'b0);
      checks++;
      if (match !== 1'b0) begin
        errors++; $display("FAIL gap_cycle%0d got %0b want 0", i, match);
      end
    end
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (match !== 1'b0) begin
      errors++; $display("FAIL gap_third got %0b want 0", match);
    end
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (match !== 1'b1 || match_cnt !== 8'd1) begin
      errors++; $display("FAIL gap_final got m=%0b cnt=%0d want m=1 cnt=1", match, match_cnt);
    end
  endtask

  task automatic test_clear_priority();
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    checks++;
    if (match !== 1'b0 || match_cnt !== 8'd0 || primed !== 1'b0) begin
      errors++; $display("FAIL clr_priority got m=%0b cnt=%0d p=%0b want 0/0/0", match, match_cnt, primed);
    end
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (match !== 1'b0) begin
      errors++; $display("FAIL clr_early got %0b want 0", match);
    end
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (match !== 1'b1 || match_cnt !== 8'd1) begin
      errors++; $display("FAIL clr_rematch got m=%0b cnt=%0d want m=1 cnt=1", match, match_cnt);
    end
  endtask

  task automatic test_saturation();
    logic [15:0] s;
    logic [1:0]  exp_cnt [5];
    int          k;
    s = 16'b1011011011011011;
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    k = 0;
    step(1'b0, 1'b0, 1'b1);
    for (int i = 15; i >= 0; i--) begin
      step(1'b1, s[i], 1'b0);
      if ((16 - i) % 3 == 1 && (16 - i) >= 4) begin
        checks++;
        if (match_s !== 1'b1 || match_cnt_s !== exp_cnt[k]) begin
          errors++; $display("FAIL sat_match%0d got m=%0b cnt=%0d want m=1 cnt=%0d", k + 1, match_s, match_cnt_s, exp_cnt[k]);
        end
        k++;
      end
    end
    checks++;
    if (match_cnt !== 8'd5) begin
      errors++; $display("FAIL sat_wide_cnt got %0d want 5", match_cnt);
    end
  endtask

  task automatic test_zero_pattern();
    step(1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 1'b0, 1'b0);
      checks++;
      if (match_z !== (i >= 4)) begin
        errors++; $display("FAIL zero_bit%0d got %0b want %0b", i, match_z, (i >= 4));
      end
    end
    checks++;
    if (match_cnt_z !== 8'd2) begin
      errors++; $display("FAIL zero_cnt got %0d want 2", match_cnt_z);
    end
  endtask

  task automatic test_upstream();
    logic [3:0] s;
    s = 4'b1011;
    ff_d = 1'b0;
    step(1'b0, 1'b0, 1'b1);
    for (int i = 3; i >= 0; i--) begin
      ff_d = s[i];
      step(1'b1, s[i], 1'b0);
    end
    checks++;
    if (match !== 1'b1 || match_f !== 1'b0) begin
      errors++; $display("FAIL ff_direct got direct=%0b ff=%0b want 1/0", match, match_f);
    end
    ff_d = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (match_f !== 1'b1 || match !== 1'b0) begin
      errors++; $display("FAIL ff_delayed got direct=%0b ff=%0b want 0/1", match, match_f);
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_gaps();
    test_clear_priority();
    test_saturation();
    test_zero_pattern();
    test_upstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
